// File: rtl/bus_display_pkg.sv
// Purpose : Shared definitions for the bus display block: converter state
//           encoding, 7-segment patterns, digit count and the double-dabble
//           step used by the binary-to-BCD converter.
// Ports   : none (package).
package bus_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS  = 4;
    localparam int DIGIT_W     = $clog2(NUM_DIGITS);
    localparam int SHIFT_STEPS = 8;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // One double-dabble iteration on {hundreds, tens, units, binary}:
    // every BCD nibble that is 5 or more gets 3 added so that the following
    // left shift carries correctly into the next decade.
    function automatic logic [19:0] dabbleStep(input logic [19:0] acc);
        logic [19:0] adj;
        adj = acc;
        for (int n = 0; n < 3; n++) begin
            if (adj[8 + 4*n +: 4] >= 4'd5) begin
                adj[8 + 4*n +: 4] = adj[8 + 4*n +: 4] + 4'd3;
            end
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bus_display_seg7_decoder.sv
// Purpose : Combinational 7-segment lookup for one display digit.
// Ports   : i_digit    - BCD digit 0-9 (other codes show blank)
//           i_blank    - force all segments off (highest priority)
//           i_minus    - show only segment g (minus sign)
//           o_segments - {g,f,e,d,c,b,a}, active high
module seg7_decoder
    import bus_display_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_minus,
    output logic [6:0] o_segments
);

    always_comb begin
        o_segments = SEG_BLANK;
        if (i_blank) begin
            o_segments = SEG_BLANK;
        end else if (i_minus) begin
            o_segments = SEG_MINUS;
        end else begin
            case (i_digit)
                4'd0:    o_segments = SEG_0;
                4'd1:    o_segments = SEG_1;
                4'd2:    o_segments = SEG_2;
                4'd3:    o_segments = SEG_3;
                4'd4:    o_segments = SEG_4;
                4'd5:    o_segments = SEG_5;
                4'd6:    o_segments = SEG_6;
                4'd7:    o_segments = SEG_7;
                4'd8:    o_segments = SEG_8;
                4'd9:    o_segments = SEG_9;
                default: o_segments = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bus_display.sv
// Purpose : Bus-attached 4-digit display. Captures a byte from the CPU bus,
//           converts it (optionally as two's complement) to sign + 3 BCD
//           digits with a sequential double-dabble, and scans the result
//           onto a multiplexed 7-segment display. All state changes on the
//           falling clock edge, like the other bus agents.
// Ports   : i_clk      - system clock (falling edge active)
//           i_reset    - asynchronous active-high reset
//           i_load_n   - active-low load strobe
//           i_signed   - treat loaded byte as two's complement
//           i_bus      - CPU data bus (input only)
//           o_value    - last byte loaded
//           o_busy     - conversion in progress
//           o_segments - segments of the enabled digit, {g..a}
//           o_digit_n  - active-low one-hot digit enable (units..sign)
module bus_display
    import bus_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
)(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_load_n,
    input  logic       i_signed,
    input  logic [7:0] i_bus,
    output logic [7:0] o_value,
    output logic       o_busy,
    output logic [6:0] o_segments,
    output logic [3:0] o_digit_n
);

    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    conv_state_t        r_state;
    conv_state_t        w_nextState;
    logic [7:0]         r_value;
    logic [2:0]         r_iter;
    logic [19:0]        r_shift;
    logic               r_negPending;
    logic [3:0]         r_hundreds;
    logic [3:0]         r_tens;
    logic [3:0]         r_units;
    logic               r_negative;
    logic [SCAN_W-1:0]  r_scanCount;
    logic [DIGIT_W-1:0] r_digitIdx;

    logic               w_load;
    logic               w_negIn;
    logic [7:0]         w_magnitude;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic               w_minus;

    assign w_load  = ~i_load_n;
    assign w_negIn = i_signed & i_bus[7];
    // Two's-complement negate in 8 bits; 0x80 negates to 0x80, which read
    // unsigned is exactly the required magnitude of 128.
    assign w_magnitude = w_negIn ? (~i_bus + 8'd1) : i_bus;

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A load from any state restarts the conversion, so the newest byte wins.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   w_nextState = ST_IDLE;
            ST_SHIFT:  if (r_iter == 3'(SHIFT_STEPS - 1)) w_nextState = ST_COMMIT;
            ST_COMMIT: w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
        if (w_load) begin
            w_nextState = ST_SHIFT;
        end
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_value      <= 8'h00;
            r_iter       <= 3'd0;
            r_shift      <= 20'd0;
            r_negPending <= 1'b0;
        end else if (w_load) begin
            r_value      <= i_bus;
            r_negPending <= w_negIn;
            r_shift      <= {12'd0, w_magnitude};
            r_iter       <= 3'd0;
        end else if (r_state == ST_SHIFT) begin
            r_shift <= dabbleStep(r_shift);
            r_iter  <= r_iter + 3'd1;
        end
    end

    // Displayed digits and sign change together, and only when a conversion
    // finishes without being superseded by a load on the same edge.
    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hundreds <= 4'd0;
            r_tens     <= 4'd0;
            r_units    <= 4'd0;
            r_negative <= 1'b0;
        end else if ((r_state == ST_COMMIT) && !w_load) begin
            r_hundreds <= r_shift[19:16];
            r_tens     <= r_shift[15:12];
            r_units    <= r_shift[11:8];
            r_negative <= r_negPending;
        end
    end

    always_ff @(negedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_scanCount <= '0;
            r_digitIdx  <= '0;
        end else if (r_scanCount == SCAN_W'(REFRESH_DIV - 1)) begin
            r_scanCount <= '0;
            r_digitIdx  <= r_digitIdx + 1'b1;
        end else begin
            r_scanCount <= r_scanCount + 1'b1;
        end
    end

    // Leading-zero blanking: tens only blank when hundreds is also zero.
    always_comb begin
        w_digit = r_units;
        w_blank = 1'b0;
        w_minus = 1'b0;
        case (r_digitIdx)
            2'd0: w_digit = r_units;
            2'd1: begin
                w_digit = r_tens;
                w_blank = (r_hundreds == 4'd0) && (r_tens == 4'd0);
            end
            2'd2: begin
                w_digit = r_hundreds;
                w_blank = (r_hundreds == 4'd0);
            end
            default: begin
                w_digit = 4'd0;
                w_blank = ~r_negative;
                w_minus = r_negative;
            end
        endcase
    end

    seg7_decoder u_decoder (
        .i_digit    (w_digit),
        .i_blank    (w_blank),
        .i_minus    (w_minus),
        .o_segments (o_segments)
    );

    assign o_digit_n = ~(4'b0001 << r_digitIdx);
    assign o_busy    = (r_state != ST_IDLE);
    assign o_value   = r_value;

endmodule

// File: tb/tb_bus_display.sv
module tb_bus_display;

    localparam int DIV = 4;

    logic       i_clk;
    logic       i_reset;
    logic       i_load_n;
    logic       i_signed;
    logic [7:0] i_bus;
    logic [7:0] o_value;
    logic       o_busy;
    logic [6:0] o_segments;
    logic [3:0] o_digit_n;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the display should show, in plain numbers.
    logic [7:0] mValue;
    int         mPendCount;
    int         mPendMag;
    bit         mPendNeg;
    int         mComMag;
    bit         mComNeg;
    int         mScanEdges;

    bus_display #(.REFRESH_DIV(DIV)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load_n   (i_load_n),
        .i_signed   (i_signed),
        .i_bus      (i_bus),
        .o_value    (o_value),
        .o_busy     (o_busy),
        .o_segments (o_segments),
        .o_digit_n  (o_digit_n)
    );

    initial begin
        i_clk = 1'b1;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [6:0] digitPattern(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic modelReset();
        mValue     = 8'h00;
        mPendCount = 0;
        mPendMag   = 0;
        mPendNeg   = 1'b0;
        mComMag    = 0;
        mComNeg    = 1'b0;
        mScanEdges = 0;
    endtask

    // A load restarts a 9-edge countdown; the result appears when it runs out.
    task automatic modelEdge(input logic ld, input logic sg, input logic [7:0] b);
        if (i_reset) begin
            modelReset();
            return;
        end
        mScanEdges++;
        if (!ld) begin
            mValue     = b;
            mPendNeg   = sg && b[7];
            mPendMag   = mPendNeg ? (256 - int'(b)) : int'(b);
            mPendCount = 9;
        end else if (mPendCount > 0) begin
            mPendCount--;
            if (mPendCount == 0) begin
                mComMag = mPendMag;
                mComNeg = mPendNeg;
            end
        end
    endtask

    task automatic applyStimulus(input logic ld, input logic sg, input logic [7:0] b);
        i_load_n = ld;
        i_signed = sg;
        i_bus    = b;
        @(negedge i_clk);
        modelEdge(ld, sg, b);
        @(posedge i_clk);
    endtask

    task automatic checkOutput(input string tag);
        int         idx;
        int         h;
        int         t;
        int         u;
        logic [3:0] expDn;
        logic [6:0] expSeg;
        logic       expBusy;
        idx = (mScanEdges / DIV) % 4;
        h   = mComMag / 100;
        t   = (mComMag / 10) % 10;
        u   = mComMag % 10;
        expDn      = 4'b1111;
        expDn[idx] = 1'b0;
        case (idx)
            0:       expSeg = digitPattern(u);
            1:       expSeg = (h == 0 && t == 0) ? 7'h00 : digitPattern(t);
            2:       expSeg = (h == 0) ? 7'h00 : digitPattern(h);
            default: expSeg = mComNeg ? 7'h40 : 7'h00;
        endcase
        expBusy = (mPendCount > 0);

        checks++;
        assert (o_value === mValue) else begin
            errors++;
            $error("[TB] FAIL %s value: observed %h expected %h", tag, o_value, mValue);
        end
        checks++;
        assert (o_busy === expBusy) else begin
            errors++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, o_busy, expBusy);
        end
        checks++;
        assert (o_digit_n === expDn) else begin
            errors++;
            $error("[TB] FAIL %s digit_n: observed %b expected %b", tag, o_digit_n, expDn);
        end
        checks++;
        assert (o_segments === expSeg) else begin
            errors++;
            $error("[TB] FAIL %s segments: observed %h expected %h", tag, o_segments, expSeg);
        end
    endtask

    task automatic idleEdges(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, 1'b0, 8'h00);
            checkOutput(tag);
        end
    endtask

    task automatic loadByte(input logic sg, input logic [7:0] b, input string tag);
        applyStimulus(1'b0, sg, b);
        checkOutput(tag);
    endtask

    initial begin
        modelReset();
        i_reset  = 1'b1;
        i_load_n = 1'b1;
        i_signed = 1'b0;
        i_bus    = 8'h00;
        #1;
        checkOutput("reset");

        // Loads during reset must be ignored.
        applyStimulus(1'b0, 1'b0, 8'h55);
        checkOutput("loadInReset");
        applyStimulus(1'b1, 1'b0, 8'h00);
        i_reset = 1'b0;
        idleEdges(2, "afterReset");

        $display("[TB] 0xFF unsigned");
        loadByte(1'b0, 8'hFF, "ffUnsLoad");
        idleEdges(16, "ffUns");

        $display("[TB] 0xFF signed");
        loadByte(1'b1, 8'hFF, "ffSgnLoad");
        idleEdges(16, "ffSgn");

        $display("[TB] 0x80 signed, 0x00 unsigned");
        loadByte(1'b1, 8'h80, "x80SgnLoad");
        idleEdges(16, "x80Sgn");
        loadByte(1'b0, 8'h00, "zeroLoad");
        idleEdges(16, "zero");

        $display("[TB] reload during conversion");
        loadByte(1'b0, 8'h07, "firstLoad");
        idleEdges(3, "firstBusy");
        loadByte(1'b0, 8'h2A, "secondLoad");
        idleEdges(16, "second");

        $display("[TB] reset during conversion");
        loadByte(1'b0, 8'h63, "x63Load");
        idleEdges(3, "x63Busy");
        i_reset = 1'b1;
        modelReset();
        #1;
        checkOutput("resetMid");
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("resetHold");
        i_reset = 1'b0;
        idleEdges(12, "afterResetMid");

        $display("[TB] randomized loads with scanning");
        for (int k = 0; k < 300; k++) begin
            logic       ld;
            logic       sg;
            logic [7:0] b;
            ld = ($urandom_range(0, 4) != 0);
            sg = 1'($urandom_range(0, 1));
            b  = 8'($urandom_range(0, 255));
            applyStimulus(ld, sg, b);
            checkOutput("random");
        end
        idleEdges(16, "randomTail");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
